// File: rtl/interp_pkg.sv
// ----------------------------------------------------------------------------
// interp_pkg
// Shared types and defaults for the interpolation run controller.
//   seq_state_t     : states of the run sequencer
//   ADDR_W          : data-memory address/data width
//   DONE_ADDR_DEF   : default address the program writes to flag completion
//   DONE_VALUE_DEF  : default data value that counts as "done"
// ----------------------------------------------------------------------------
package interp_pkg;

    localparam int ADDR_W = 19;

    localparam logic [ADDR_W-1:0] DONE_ADDR_DEF  = 19'h7FFFE;
    localparam logic [ADDR_W-1:0] DONE_VALUE_DEF = 19'h1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE_Q  = 3'd1,
        WAIT_VS1 = 3'd2,
        RUN      = 3'd3,
        WAIT_VS2 = 3'd4,
        SHOW     = 3'd5,
        WAIT_VS0 = 3'd6,
        ABORT    = 3'd7
    } seq_state_t;

endpackage

// File: rtl/btn_edge_sync.sv
// ----------------------------------------------------------------------------
// btn_edge_sync
// Brings an asynchronous active-high button into the clock domain through a
// two-flop synchronizer and emits a registered one-cycle pulse on its rising
// edge. Raw rising edge to pulse is three clock edges.
//   clk      in  system clock
//   reset    in  asynchronous active-low reset
//   btn_i    in  raw button level
//   pulse_o  out one-cycle pulse per press
// ----------------------------------------------------------------------------
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    // Synchronizer chain, delayed copy for edge detect, and the registered
    // pulse so downstream logic never sees a combinational glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/interp_sequencer.sv
// ----------------------------------------------------------------------------
// interp_sequencer
// Run controller for the interpolation flow. Latches the quadrant, writes it to
// memory address 0, hands memory/VGA to the processor on a frame boundary,
// detects completion by a write to DONE_ADDR and aborts on a cycle timeout.
//   clk, reset          clock and asynchronous active-low reset
//   btn_start           raw start button (async, active-high)
//   sw_cuadrante        requested quadrant
//   vga_vsync_start     one-cycle frame-boundary pulse
//   cpu_mem_we/adr/wd   processor data-memory write port
//   interpolacion       0 = original image / controller owns memory, 1 = processor
//   cuadrante           latched quadrant
//   mem_we              muxed memory write enable
//   cpu_reset_n         processor reset, active-low
//   busy, done          status (done while showing the result)
//   timeout, bad_sel    sticky error flags
// ----------------------------------------------------------------------------
module interp_sequencer
    import interp_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DONE_ADDR  = DONE_ADDR_DEF,
    parameter logic [ADDR_W-1:0] DONE_VALUE = DONE_VALUE_DEF,
    parameter logic [3:0]        CUAD_MAX   = 4'd15,
    parameter logic [31:0]       TIMEOUT    = 32'd50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_start,
    input  logic [3:0]        sw_cuadrante,
    input  logic              vga_vsync_start,
    input  logic              cpu_mem_we,
    input  logic [ADDR_W-1:0] cpu_mem_adr,
    input  logic [ADDR_W-1:0] cpu_mem_wd,
    output logic              interpolacion,
    output logic [3:0]        cuadrante,
    output logic              mem_we,
    output logic              cpu_reset_n,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              bad_sel
);

    seq_state_t  state_q, state_d;
    logic [3:0]  cuad_q, cuad_d;
    logic        timeout_q, timeout_d;
    logic        bad_sel_q, bad_sel_d;
    logic [31:0] cnt_q, cnt_d;

    logic start_p;
    logic sw_ok;
    logic done_hit;
    logic cnt_expired;

    btn_edge_sync u_start_sync (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_start),
        .pulse_o (start_p)
    );

    assign sw_ok       = (sw_cuadrante <= CUAD_MAX);
    assign done_hit    = cpu_mem_we && (cpu_mem_adr == DONE_ADDR) && (cpu_mem_wd == DONE_VALUE);
    assign cnt_expired = (cnt_q == TIMEOUT - 32'd1);

    // State register plus the latched quadrant, sticky flags and run counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cuad_q    <= 4'd0;
            timeout_q <= 1'b0;
            bad_sel_q <= 1'b0;
            cnt_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            cuad_q    <= cuad_d;
            timeout_q <= timeout_d;
            bad_sel_q <= bad_sel_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic. Vsync is only examined while already sitting in a wait
    // state, so a pulse on the entry edge belongs to the previous state and is
    // dropped. A done write takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_p && sw_ok) state_d = WRITE_Q;
            WRITE_Q:  state_d = WAIT_VS1;
            WAIT_VS1: if (vga_vsync_start) state_d = RUN;
            RUN: begin
                if (done_hit)         state_d = WAIT_VS2;
                else if (cnt_expired) state_d = ABORT;
            end
            WAIT_VS2: if (vga_vsync_start) state_d = SHOW;
            SHOW:     if (start_p) state_d = WAIT_VS0;
            WAIT_VS0: if (vga_vsync_start) state_d = IDLE;
            ABORT:    if (vga_vsync_start) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath next values. The counter runs only in RUN and is held at zero
    // elsewhere, so it always starts from zero on entry and cannot wrap
    // because the timeout leaves RUN first.
    always_comb begin
        cuad_d    = cuad_q;
        timeout_d = timeout_q;
        bad_sel_d = bad_sel_q;
        cnt_d     = 32'd0;
        if (state_q == IDLE && start_p) begin
            if (sw_ok) begin
                cuad_d    = sw_cuadrante;
                timeout_d = 1'b0;
                bad_sel_d = 1'b0;
            end else begin
                bad_sel_d = 1'b1;
            end
        end
        if (state_q == RUN) begin
            cnt_d = cnt_q + 32'd1;
            if (!done_hit && cnt_expired) timeout_d = 1'b1;
        end
    end

    // Outputs decode straight from the state register, so an asynchronous
    // reset drops the processor and memory ownership without waiting a clock.
    always_comb begin
        interpolacion = 1'b0;
        mem_we        = 1'b0;
        cpu_reset_n   = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state_q)
            IDLE:     busy = 1'b0;
            WRITE_Q:  mem_we = 1'b1;
            WAIT_VS1: ;
            RUN: begin
                interpolacion = 1'b1;
                cpu_reset_n   = 1'b1;
                mem_we        = cpu_mem_we;
            end
            WAIT_VS2: interpolacion = 1'b1;
            SHOW: begin
                interpolacion = 1'b1;
                busy          = 1'b0;
                done          = 1'b1;
            end
            WAIT_VS0: interpolacion = 1'b1;
            ABORT:    interpolacion = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    assign cuadrante = cuad_q;
    assign timeout   = timeout_q;
    assign bad_sel   = bad_sel_q;

endmodule

// File: tb/tb_interp_sequencer.sv
// ----------------------------------------------------------------------------
// tb_interp_sequencer
// Directed bench for interp_sequencer built with CUAD_MAX=8 and TIMEOUT=100.
// ----------------------------------------------------------------------------
module tb_interp_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_start = 1'b0;
    logic [3:0]  sw_cuadrante = 4'd0;
    logic        vga_vsync_start = 1'b0;
    logic        cpu_mem_we = 1'b0;
    logic [18:0] cpu_mem_adr = 19'd0;
    logic [18:0] cpu_mem_wd = 19'd0;
    logic        interpolacion;
    logic [3:0]  cuadrante;
    logic        mem_we;
    logic        cpu_reset_n;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        bad_sel;

    int testsRun = 0;
    int testsFailed = 0;

    interp_sequencer #(
        .DONE_ADDR  (19'h7FFFE),
        .DONE_VALUE (19'h1),
        .CUAD_MAX   (4'd8),
        .TIMEOUT    (32'd100)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .btn_start       (btn_start),
        .sw_cuadrante    (sw_cuadrante),
        .vga_vsync_start (vga_vsync_start),
        .cpu_mem_we      (cpu_mem_we),
        .cpu_mem_adr     (cpu_mem_adr),
        .cpu_mem_wd      (cpu_mem_wd),
        .interpolacion   (interpolacion),
        .cuadrante       (cuadrante),
        .mem_we          (mem_we),
        .cpu_reset_n     (cpu_reset_n),
        .busy            (busy),
        .done            (done),
        .timeout         (timeout),
        .bad_sel         (bad_sel)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    // Advance one clock and settle 1 ns past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold the button for 4 cycles then release for 4; a press taken in IDLE
    // reaches WAIT_VS1 before this returns.
    task automatic press_start();
        btn_start = 1'b1;
        ticks(4);
        btn_start = 1'b0;
        ticks(4);
    endtask

    task automatic pulse_vsync();
        vga_vsync_start = 1'b1;
        tick();
        vga_vsync_start = 1'b0;
    endtask

    task automatic go_to_run(input logic [3:0] sw);
        sw_cuadrante = sw;
        press_start();
        pulse_vsync();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ticks(2);
        testsRun++;
        if ({interpolacion, cuadrante, mem_we, cpu_reset_n, busy, done, timeout, bad_sel} !== 11'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %b expected all zero",
                     {interpolacion, cuadrante, mem_we, cpu_reset_n, busy, done, timeout, bad_sel});
        end
        reset = 1'b1;
        tick();
    endtask

    // Start with sw=5: single WRITE_Q cycle four edges after the raw press,
    // then RUN right after the vsync edge.
    task automatic test_start_run();
        int weCount;
        int weStep;
        weCount = 0;
        weStep = -1;
        sw_cuadrante = 4'd5;
        btn_start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 4) btn_start = 1'b0;
            if (mem_we) begin
                weCount++;
                weStep = k;
                testsRun++;
                if (interpolacion !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL write_q_interp: got %b expected 0", interpolacion);
                end
            end
        end
        testsRun++;
        if (weCount !== 1 || weStep !== 4) begin
            testsFailed++;
            $display("[TB] FAIL write_q_pulse: got count=%0d step=%0d expected count=1 step=4", weCount, weStep);
        end
        testsRun++;
        if (cuadrante !== 4'd5) begin
            testsFailed++;
            $display("[TB] FAIL cuadrante_latch: got %0d expected 5", cuadrante);
        end
        ticks(10);
        testsRun++;
        if ({busy, interpolacion, cpu_reset_n, done} !== 4'b1000) begin
            testsFailed++;
            $display("[TB] FAIL wait_vs1_outputs: got %b expected 1000", {busy, interpolacion, cpu_reset_n, done});
        end
        pulse_vsync();
        testsRun++;
        if ({interpolacion, cpu_reset_n, busy} !== 3'b111) begin
            testsFailed++;
            $display("[TB] FAIL run_entry: got %b expected 111", {interpolacion, cpu_reset_n, busy});
        end
    endtask

    // Wrong done value, ignored start press, then real done write (with a vsync
    // on the entry edge that must be ignored), then SHOW.
    task automatic test_done_write();
        cpu_mem_we = 1'b1;
        cpu_mem_adr = 19'h7FFFE;
        cpu_mem_wd = 19'd2;
        #1;
        testsRun++;
        if (mem_we !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL run_we_mux: got %b expected 1", mem_we);
        end
        tick();
        cpu_mem_we = 1'b0;
        testsRun++;
        if (cpu_reset_n !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL wrong_done_value: cpu_reset_n got %b expected 1", cpu_reset_n);
        end
        press_start();
        testsRun++;
        if ({cpu_reset_n, interpolacion, bad_sel, done} !== 4'b1100) begin
            testsFailed++;
            $display("[TB] FAIL start_in_run: got %b expected 1100", {cpu_reset_n, interpolacion, bad_sel, done});
        end
        cpu_mem_we = 1'b1;
        cpu_mem_wd = 19'd1;
        vga_vsync_start = 1'b1;
        tick();
        vga_vsync_start = 1'b0;
        testsRun++;
        if ({cpu_reset_n, interpolacion, busy, done, mem_we} !== 5'b01100) begin
            testsFailed++;
            $display("[TB] FAIL wait_vs2_entry: got %b expected 01100", {cpu_reset_n, interpolacion, busy, done, mem_we});
        end
        cpu_mem_we = 1'b0;
        tick();
        pulse_vsync();
        testsRun++;
        if ({done, busy, interpolacion, cpu_reset_n} !== 4'b1010) begin
            testsFailed++;
            $display("[TB] FAIL show_state: got %b expected 1010", {done, busy, interpolacion, cpu_reset_n});
        end
    endtask

    // Start from SHOW goes to WAIT_VS0, vsync returns to IDLE.
    task automatic test_show_exit();
        int budget;
        budget = 0;
        btn_start = 1'b1;
        while (done === 1'b1 && budget < 10) begin
            tick();
            budget++;
        end
        btn_start = 1'b0;
        testsRun++;
        if ({done, busy, interpolacion} !== 3'b011) begin
            testsFailed++;
            $display("[TB] FAIL wait_vs0: got %b expected 011 after %0d cycles", {done, busy, interpolacion}, budget);
        end
        ticks(4);
        pulse_vsync();
        testsRun++;
        if ({busy, interpolacion, done} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL back_to_idle: got %b expected 000", {busy, interpolacion, done});
        end
    endtask

    // 100 RUN cycles without a done write abort; refused start keeps timeout
    // and never writes memory; an accepted start clears both flags.
    task automatic test_timeout();
        int weSeen;
        weSeen = 0;
        go_to_run(4'd3);
        ticks(99);
        testsRun++;
        if ({cpu_reset_n, timeout} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL run_cycle_100: got %b expected 10", {cpu_reset_n, timeout});
        end
        tick();
        testsRun++;
        if ({cpu_reset_n, timeout, interpolacion, busy} !== 4'b0111) begin
            testsFailed++;
            $display("[TB] FAIL abort_entry: got %b expected 0111", {cpu_reset_n, timeout, interpolacion, busy});
        end
        pulse_vsync();
        testsRun++;
        if ({busy, interpolacion, timeout} !== 3'b001) begin
            testsFailed++;
            $display("[TB] FAIL abort_to_idle: got %b expected 001", {busy, interpolacion, timeout});
        end
        sw_cuadrante = 4'd9;
        btn_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 4) btn_start = 1'b0;
            if (mem_we) weSeen++;
        end
        testsRun++;
        if ({bad_sel, busy, timeout, cuadrante} !== {3'b101, 4'd3} || weSeen !== 0) begin
            testsFailed++;
            $display("[TB] FAIL bad_sel_refuse: got flags=%b cuad=%0d we=%0d expected flags=101 cuad=3 we=0",
                     {bad_sel, busy, timeout}, cuadrante, weSeen);
        end
        sw_cuadrante = 4'd2;
        press_start();
        testsRun++;
        if ({timeout, bad_sel, busy, cuadrante} !== {3'b001, 4'd2}) begin
            testsFailed++;
            $display("[TB] FAIL restart_clears: got flags=%b cuad=%0d expected flags=001 cuad=2",
                     {timeout, bad_sel, busy}, cuadrante);
        end
    endtask

    // Done write lands on the same edge the counter would expire: done wins.
    task automatic test_done_timeout_tie();
        pulse_vsync();
        ticks(99);
        cpu_mem_we = 1'b1;
        cpu_mem_adr = 19'h7FFFE;
        cpu_mem_wd = 19'd1;
        tick();
        cpu_mem_we = 1'b0;
        testsRun++;
        if ({cpu_reset_n, timeout, interpolacion, busy} !== 4'b0011) begin
            testsFailed++;
            $display("[TB] FAIL done_timeout_tie: got %b expected 0011", {cpu_reset_n, timeout, interpolacion, busy});
        end
        pulse_vsync();
        testsRun++;
        if ({done, timeout} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL tie_show: got %b expected 10", {done, timeout});
        end
        press_start();
        pulse_vsync();
    endtask

    // Asynchronous reset in the middle of a clock cycle during RUN.
    task automatic test_reset_mid_run();
        go_to_run(4'd7);
        ticks(5);
        #2;
        reset = 1'b0;
        #1;
        testsRun++;
        if ({interpolacion, cuadrante, mem_we, cpu_reset_n, busy, done, timeout, bad_sel} !== 11'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_run: got %b expected all zero",
                     {interpolacion, cuadrante, mem_we, cpu_reset_n, busy, done, timeout, bad_sel});
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_start_run();
        test_done_write();
        test_show_exit();
        test_timeout();
        test_done_timeout_tie();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
